// File: rtl/bsg_mem_1rw_sync_stream_adapter.sv
// Valid/ready request front-end for a 1rw sync RAM; read data leaves on valid/yumi 1 cycle after accept (bypass).
// Backpressure: ready_and_o drops when buffered + in-flight reads reach 2, so a stalled consumer never loses data.
module bsg_mem_1rw_sync_stream_adapter #(
  parameter int width_p       = 8,
  parameter int els_p         = 16,
  parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_and_o,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  input  logic                     yumi_i,
  output logic                     mem_v_o,
  output logic                     mem_w_o,
  output logic [addr_width_lp-1:0] mem_addr_o,
  output logic [width_p-1:0]       mem_data_o,
  input  logic [width_p-1:0]       mem_data_i
);

  logic               inflight_r;
  logic               rd_ptr_r;
  logic               wr_ptr_r;
  logic [1:0]         count_r;
  logic [width_p-1:0] buf_r [2];

  logic [1:0] slots;
  logic       buf_empty;
  logic       deq;
  logic       pop_buf;
  logic       enq;

  assign slots       = count_r + {1'b0, inflight_r};
  assign ready_and_o = reset_n_i & (slots < 2'd2);
  assign buf_empty   = (count_r == 2'd0);

  assign mem_v_o    = v_i & ready_and_o;
  assign mem_w_o    = w_i;
  assign mem_addr_o = addr_i;
  assign mem_data_o = data_i;

  // RAM data goes straight out only when nothing older is waiting in the buffer.
  always_comb begin
    v_o    = 1'b0;
    data_o = buf_r[rd_ptr_r];
    if (reset_n_i) begin
      v_o = inflight_r | ~buf_empty;
      if (inflight_r && buf_empty)
        data_o = mem_data_i;
    end
  end

  assign deq     = v_o & yumi_i;
  assign pop_buf = deq & ~buf_empty;
  assign enq     = inflight_r & ~(buf_empty & yumi_i);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      inflight_r <= 1'b0;
      count_r    <= 2'd0;
      rd_ptr_r   <= 1'b0;
      wr_ptr_r   <= 1'b0;
    end else begin
      inflight_r <= mem_v_o & ~w_i;
      if (enq) begin
        buf_r[wr_ptr_r] <= mem_data_i;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop_buf)
        rd_ptr_r <= ~rd_ptr_r;
      count_r <= count_r + {1'b0, enq} - {1'b0, pop_buf};
      assert (!(enq && count_r == 2'd2));
      assert (!(yumi_i && !v_o));
    end
  end

endmodule

// File: doc/bsg_mem_1rw_sync_stream_adapter.md
# bsg_mem_1rw_sync_stream_adapter

Upstream front-end for a single-port synchronous RAM (`bsg_mem_1rw_sync` style: one read or write per cycle, read data one cycle after the request). Converts a valid/ready request stream into RAM port commands and returns read data on a valid/yumi stream. A 2-entry output buffer and credit tracking ensure read data is never dropped when the consumer stalls. Read responses are delivered strictly in request order.

## Interface
- width_p, none (required), data width in bits
- els_p, none (required), number of RAM words
- addr_width_lp, `BSG_SAFE_CLOG2(els_p)`, address width

- clk_i  in  1  clock
- reset_n_i  in  1  one clock; reset is synchronous and active-low
- v_i  in  1  request valid
- w_i  in  1  1 = write, 0 = read
- addr_i  in  addr_width_lp  request address
- data_i  in  width_p  write data
- ready_and_o  out  1  adapter accepts a request this cycle
- v_o  out  1  read data valid
- data_o  out  width_p  read data
- yumi_i  in  1  consumer takes data_o this cycle; legal only when v_o=1
- mem_v_o  out  1  RAM port valid
- mem_w_o  out  1  RAM port write enable
- mem_addr_o  out  addr_width_lp  RAM address
- mem_data_o  out  width_p  RAM write data
- mem_data_i  in  width_p  RAM read data, valid the cycle after a read

## Operation
- Request accepted when v_i & ready_and_o. mem_v_o = v_i & ready_and_o. mem_w_o, mem_addr_o and mem_data_o pass w_i, addr_i and data_i through combinationally.
- State:
  - inflight_r: 1 bit, set in the cycle after an accepted read.
  - 2-entry circular buffer with rd_ptr, wr_ptr and count (0..2).
- slots = count + inflight_r. ready_and_o = reset_n_i & (slots < 2). Registered state only; no combinational path from v_i or yumi_i. Writes are also gated by ready_and_o.
- Writes consume no slot and produce no response.
- Response path when inflight_r=1:
  - count=0: bypass. v_o=1, data_o=mem_data_i. If yumi_i=0, mem_data_i is written into the buffer at wr_ptr and count goes to 1.
  - count>0: v_o=1, data_o=buffer[rd_ptr], and mem_data_i is enqueued.
- When inflight_r=0: v_o = (count>0), data_o = buffer[rd_ptr]. data_o is don't-care when v_o=0.
- yumi_i pops the head (buffer or bypass). Enqueue and dequeue in the same cycle leave count unchanged and advance both pointers.
- Pointers wrap 1→0.
- Invariant: slots ≤ 2, so the buffer never overflows. An enqueue at count=2 is an assertion failure.
- yumi_i while v_o=0 is an assertion failure in simulation and is ignored in logic.

## Timing
- Read accepted in cycle N → v_o earliest at N+1 (bypass), data = RAM[addr] as of cycle N.
- Write accepted in cycle N → RAM updated at the N/N+1 clock edge. A read of the same address at N+1 returns the new data.
- Full throughput (one read per cycle) is sustained while yumi_i is held high:
  - slots = inflight only, and yumi at N+1 frees the slot at N+2.
  - ready_and_o may deassert for one cycle when a read is accepted while count=1. Throughput is therefore ≥ 1 read per 2 cycles under steady yumi and 1 per cycle in steady state with count=0.
- A slot freed by yumi_i takes effect on ready_and_o the next cycle.
- Reset (reset_n_i=0 at a clock edge):
  - inflight_r=0, count=0, rd_ptr=wr_ptr=0.
  - During reset: ready_and_o=0, mem_v_o=0, v_o=0.
- Reset mid-operation discards in-flight and buffered reads. The RAM contents are not touched.
- First request can be accepted in the first cycle with reset_n_i=1.

## Test plan
- Reset: hold reset_n_i=0 for 3 cycles with v_i=1 → ready_and_o=0, mem_v_o=0, v_o=0 throughout. Release → ready_and_o=1 in the first cycle.
- Write/read-back: write 0xA5 to addr 3 at N, read addr 3 at N+1 with yumi_i=1 → v_o=1, data_o=0xA5 at N+2, mem_v_o pulses once per request.
- Back-pressure: yumi_i=0, issue reads of addrs 0,1,2 (contents 10,11,12) → only 2 accepted, then ready_and_o=0. Raise yumi_i → data 10 then 11 in order, then ready_and_o=1 and addr 2 returns 12.
- Streaming: 16 back-to-back reads with yumi_i=1 → 16 responses in order, no loss, no duplicates, v_o never 1 without a matching request.
- Simultaneous enqueue/dequeue: count=1 with a read inflight and yumi_i=1 → count stays 1, pointers advance, data ordering is preserved across the wrap.
- Reset mid-stream: 2 reads buffered, assert reset_n_i=0 for 1 cycle → v_o=0 after reset, no stale data returned. A subsequent read returns the correct RAM value.
